spi_accel_target: RTL and testbench
===================================

SPI_ACCEL_TARGET -- requirements
Module: spi_accel_target

Interface
REQ-001 SHALL have parameter WHO_AM_I_VAL, default 8'h33, value returned at address 0x0F.
REQ-002 SHALL have parameter MIN_HALF, default 4, minimum SCLK high/low time in CLK_50 cycles that is guaranteed to be sampled.
REQ-003 SHALL have port CLK_50  in  1  system clock, 50 MHz.
REQ-004 SHALL have port RESET_N  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port CS  in  1  SPI chip select, active-low, asynchronous to CLK_50.
REQ-006 SHALL have port SCLK  in  1  SPI clock, idle high, mode 3, asynchronous.
REQ-007 SHALL have port DIN  in  1  master-to-target serial data, MSB first.
REQ-008 SHALL have port DO  out  1  target-to-master serial data; DO_OE  out  1  DO drive enable.
REQ-009 SHALL have port SAMPLE_X/SAMPLE_Y/SAMPLE_Z  in  16 each  two's-complement left-justified sample; SAMPLE_VLD  in  1  one-cycle load strobe.
REQ-010 SHALL have port WR_STB  out  1  one-cycle pulse per accepted register write; WR_ADDR  out  6; WR_DATA  out  8.
REQ-011 SHALL have port CTRL_REG1..CTRL_REG6  out  8 each  current writable control register contents (addresses 0x20-0x25).

Function
REQ-012 CS, SCLK, DIN SHALL pass a 2-FF synchronizer; SCLK rise/fall and CS fall/rise SHALL be detected by edge compare on synchronized values.
REQ-013 DIN SHALL be sampled on each detected SCLK rising edge while CS low.
REQ-014 Frame: bit15 RW (1=read), bit14 MS (auto-increment), bits13:8 address, bits7:0 data.
REQ-015 FSM states IDLE, CMD, DATA, HOLD: IDLE->CMD on CS fall; CMD->DATA after 8th rising edge; DATA->DATA (MS=1) or DATA->HOLD (MS=0) after each 8 data bits; any state->IDLE on CS rise.
REQ-016 Write: after 8th data bit, if address writable (0x20-0x25, 0x30, 0x34), register SHALL update and WR_STB pulse one cycle later with WR_ADDR/WR_DATA; other addresses ignored, no WR_STB.
REQ-017 Read: read byte SHALL load after 8th command bit; DO_OE=1 from that point until CS rise; bit7 SHALL appear on DO at the next detected SCLK falling edge, subsequent bits on each falling edge.
REQ-018 DO SHALL change within 4 CLK_50 cycles of the physical SCLK falling edge.
REQ-019 MS=1: address SHALL increment after each data byte, wrapping 0x3F->0x00; MS=0 extra bits SHALL be ignored (HOLD).
REQ-020 Unmapped read addresses SHALL return 0x00; 0x0F returns WHO_AM_I_VAL; 0x28-0x2D return X_L,X_H,Y_L,Y_H,Z_L,Z_H.
REQ-021 SAMPLE_VLD with CS high SHALL load OUT registers next cycle; with CS low it SHALL be held pending (latest value wins) and applied on CS rise.
REQ-022 CS rise before 16 bits SHALL abort: no register update, no WR_STB, DO_OE=0 next cycle.
REQ-023 SCLK edges while CS high SHALL be ignored.

Reset
REQ-024 RESET_N low SHALL asynchronously force: FSM IDLE, DO=0, DO_OE=0, WR_STB=0, WR_ADDR=0, WR_DATA=0, CTRL_REG1=8'h07, CTRL_REG2..6=0, INT1_CFG=INT2_CFG=0, OUT registers=0, pending sample cleared.
REQ-025 Reset mid-frame SHALL discard the frame; after release, the first recognized frame begins at the next CS fall.

Structure
REQ-026 Shared package spi_accel_pkg SHALL hold register address constants, reset values, writable-address list and FSM state enum.
REQ-027 Sub-module spi_pin_sync SHALL implement synchronizers and edge detection for CS, SCLK, DIN.

Verification
REQ-028 Write frame 0x2097 -> CTRL_REG1=0x97, single WR_STB with WR_ADDR=0x20, WR_DATA=0x97.
REQ-029 Read frame 0x8F00 -> DO_OE high, DO shifts 0x33 in data bits.
REQ-030 SAMPLE_X=0x1234, SAMPLE_VLD with CS high, then 24-bit frame 0xE8 + 16 clocks -> DO returns 0x34 then 0x12.
REQ-031 CS rises after 10 bits of 0x2155 -> CTRL_REG2 stays 0x00, no WR_STB, DO_OE=0.
REQ-032 SAMPLE_VLD (Z=0x8000) during a read of 0xAD -> returned byte old value; after CS rise, read 0xAD returns 0x80.
REQ-033 Write 0x0F55 -> no WR_STB, subsequent 0x8F00 read still returns 0x33; RESET_N pulse mid-frame -> CTRL_REG1=0x07.

Source files
------------

// File: rtl/spi_accel_pkg.sv
// Shared definitions for the SPI accelerometer target: register map,
// reset values, the writable-address list and the frame FSM states.
package spi_accel_pkg;

  // Register addresses (6-bit SPI address space).
  localparam logic [5:0] ADDR_WHO_AM_I  = 6'h0F;
  localparam logic [5:0] ADDR_CTRL_REG1 = 6'h20;
  localparam logic [5:0] ADDR_CTRL_REG2 = 6'h21;
  localparam logic [5:0] ADDR_CTRL_REG3 = 6'h22;
  localparam logic [5:0] ADDR_CTRL_REG4 = 6'h23;
  localparam logic [5:0] ADDR_CTRL_REG5 = 6'h24;
  localparam logic [5:0] ADDR_CTRL_REG6 = 6'h25;
  localparam logic [5:0] ADDR_OUT_X_L   = 6'h28;
  localparam logic [5:0] ADDR_OUT_X_H   = 6'h29;
  localparam logic [5:0] ADDR_OUT_Y_L   = 6'h2A;
  localparam logic [5:0] ADDR_OUT_Y_H   = 6'h2B;
  localparam logic [5:0] ADDR_OUT_Z_L   = 6'h2C;
  localparam logic [5:0] ADDR_OUT_Z_H   = 6'h2D;
  localparam logic [5:0] ADDR_INT1_CFG  = 6'h30;
  localparam logic [5:0] ADDR_INT2_CFG  = 6'h34;

  // Number of control registers at ADDR_CTRL_REG1 onwards.
  localparam int N_CTRL = 6;

  // Reset values of CTRL_REG1..CTRL_REG6, index 0 = CTRL_REG1.
  localparam logic [N_CTRL-1:0][7:0] CTRL_RST_VALS =
    {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h07};
  localparam logic [7:0] INT_CFG_RST = 8'h00;

  // Addresses that accept writes; everything else silently drops write data.
  localparam int N_WRITABLE = 8;
  localparam logic [N_WRITABLE-1:0][5:0] WRITABLE_ADDRS =
    {ADDR_INT2_CFG, ADDR_INT1_CFG,
     ADDR_CTRL_REG6, ADDR_CTRL_REG5, ADDR_CTRL_REG4,
     ADDR_CTRL_REG3, ADDR_CTRL_REG2, ADDR_CTRL_REG1};

  // Clock cycles from a pin change to its detected edge (2 sync stages + compare).
  localparam int SYNC_LATENCY = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_HOLD = 2'd3
  } spi_state_e;

  function automatic logic is_writable(input logic [5:0] addr);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_WRITABLE; i++) begin
      if (addr == WRITABLE_ADDRS[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Brings the asynchronous SPI pins into the CLK_50 domain and derives
// single-cycle edge strobes for CS and SCLK from the synchronized levels.
module spi_pin_sync (
  input  logic CLK_50,
  input  logic RESET_N,
  input  logic CS,
  input  logic SCLK,
  input  logic DIN,
  output logic cs_s,
  output logic din_s,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_fall,
  output logic cs_rise
);

  logic [1:0] cs_ff;
  logic [1:0] sclk_ff;
  logic [1:0] din_ff;
  logic       cs_d;
  logic       sclk_d;

  // Two-stage synchronizers plus one delayed copy for edge comparison.
  // CS resets to "low" so a chip select already held low across reset
  // produces no falling edge: a frame in flight is never picked up halfway.
  // NOTE: non-blocking assignments make every stage capture the previous
  // stage's old value, which is what makes this a shift chain.
  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      cs_ff   <= 2'b00;
      sclk_ff <= 2'b11;
      din_ff  <= 2'b00;
      cs_d    <= 1'b0;
      sclk_d  <= 1'b1;
    end else begin
      cs_ff   <= {cs_ff[0], CS};
      sclk_ff <= {sclk_ff[0], SCLK};
      din_ff  <= {din_ff[0], DIN};
      cs_d    <= cs_ff[1];
      sclk_d  <= sclk_ff[1];
    end
  end

  assign cs_s      = cs_ff[1];
  assign din_s     = din_ff[1];
  assign sclk_rise = sclk_ff[1] & ~sclk_d;
  assign sclk_fall = ~sclk_ff[1] & sclk_d;
  assign cs_fall   = ~cs_ff[1] & cs_d;
  assign cs_rise   = cs_ff[1] & ~cs_d;

endmodule

// File: rtl/spi_accel_target.sv
// SPI (mode 3) register target of an accelerometer: 16-bit frames with
// read/auto-increment flags, control/interrupt registers, and output
// sample registers that stay frozen while a transaction is in progress.
module spi_accel_target
  import spi_accel_pkg::*;
#(
  parameter logic [7:0] WHO_AM_I_VAL = 8'h33,
  parameter int         MIN_HALF     = 4
) (
  input  logic        CLK_50,
  input  logic        RESET_N,
  input  logic        CS,
  input  logic        SCLK,
  input  logic        DIN,
  output logic        DO,
  output logic        DO_OE,
  input  logic [15:0] SAMPLE_X,
  input  logic [15:0] SAMPLE_Y,
  input  logic [15:0] SAMPLE_Z,
  input  logic        SAMPLE_VLD,
  output logic        WR_STB,
  output logic [5:0]  WR_ADDR,
  output logic [7:0]  WR_DATA,
  output logic [7:0]  CTRL_REG1,
  output logic [7:0]  CTRL_REG2,
  output logic [7:0]  CTRL_REG3,
  output logic [7:0]  CTRL_REG4,
  output logic [7:0]  CTRL_REG5,
  output logic [7:0]  CTRL_REG6
);

  // SCLK phases shorter than the sync + edge-detect latency cannot be seen reliably.
  if (MIN_HALF < SYNC_LATENCY) begin : g_min_half_check
    $error("MIN_HALF must be at least %0d", SYNC_LATENCY);
  end

  logic cs_s, din_s, sclk_rise, sclk_fall, cs_fall, cs_rise;

  spi_pin_sync u_pin_sync (
    .CLK_50    (CLK_50),
    .RESET_N   (RESET_N),
    .CS        (CS),
    .SCLK      (SCLK),
    .DIN       (DIN),
    .cs_s      (cs_s),
    .din_s     (din_s),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise)
  );

  spi_state_e state_q, state_d;

  logic [2:0] bit_cnt_q;
  logic [6:0] rx_sr_q;
  logic       rw_q;
  logic       ms_q;
  logic [5:0] addr_q;
  logic [7:0] tx_sr_q;
  logic       do_q;
  logic       do_oe_q;

  logic       wr_pend_q;
  logic       wr_stb_q;
  logic [5:0] wr_addr_q;
  logic [7:0] wr_data_q;

  logic [7:0] ctrl_q [N_CTRL];
  logic [7:0] int1_q, int2_q;

  logic [15:0] out_x_q, out_y_q, out_z_q;
  logic [15:0] pend_x_q, pend_y_q, pend_z_q;
  logic        pend_vld_q;

  logic       sclk_rise_g, sclk_fall_g;
  logic       shifting, cmd_done, data_done, wr_en;
  logic [7:0] rx_byte;
  logic [5:0] rd_addr;
  logic [7:0] rd_data;

  // SCLK activity only counts while the target is selected.
  assign sclk_rise_g = sclk_rise & ~cs_s;
  assign sclk_fall_g = sclk_fall & ~cs_s;

  assign rx_byte   = {rx_sr_q, din_s};
  assign shifting  = sclk_rise_g && (state_q == ST_CMD || state_q == ST_DATA);
  assign cmd_done  = shifting && (bit_cnt_q == 3'd7) && (state_q == ST_CMD);
  assign data_done = shifting && (bit_cnt_q == 3'd7) && (state_q == ST_DATA);
  assign wr_en     = data_done && !rw_q && is_writable(addr_q);

  // The read byte is fetched either for the address just decoded or for
  // the next auto-increment address.
  assign rd_addr = cmd_done ? rx_byte[5:0] : addr_q + 6'd1;

  // Frame state register.
  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Frame sequencing: command byte, then data bytes until CS rises.
  // NOTE: state_d is given a default before the case so that no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (cs_fall)   state_d = ST_CMD;
      ST_CMD:  if (cmd_done)  state_d = ST_DATA;
      ST_DATA: if (data_done) state_d = ms_q ? ST_DATA : ST_HOLD;
      ST_HOLD: state_d = ST_HOLD;
      default: state_d = ST_IDLE;
    endcase
    if (cs_rise) state_d = ST_IDLE;
  end

  // Serial datapath: bit counting, command decode, address stepping, DO shifting.
  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      bit_cnt_q <= 3'd0;
      rx_sr_q   <= 7'd0;
      rw_q      <= 1'b0;
      ms_q      <= 1'b0;
      addr_q    <= 6'd0;
      tx_sr_q   <= 8'd0;
      do_q      <= 1'b0;
      do_oe_q   <= 1'b0;
    end else begin
      if (cs_fall) begin
        bit_cnt_q <= 3'd0;
      end else if (shifting) begin
        bit_cnt_q <= bit_cnt_q + 3'd1;
        rx_sr_q   <= rx_byte[6:0];
      end

      if (cmd_done) begin
        rw_q   <= rx_byte[7];
        ms_q   <= rx_byte[6];
        addr_q <= rx_byte[5:0];
        if (rx_byte[7]) begin
          tx_sr_q <= rd_data;
          do_oe_q <= 1'b1;
        end
      end else if (data_done && ms_q) begin
        addr_q <= addr_q + 6'd1;
        if (rw_q) tx_sr_q <= rd_data;
      end else if (do_oe_q && sclk_fall_g) begin
        do_q    <= tx_sr_q[7];
        tx_sr_q <= {tx_sr_q[6:0], 1'b0};
      end

      if (cs_rise) begin
        do_oe_q <= 1'b0;
        do_q    <= 1'b0;
      end
    end
  end

  // Write notification: address/data follow the register update, strobe one cycle later.
  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_pend_q <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= 6'd0;
      wr_data_q <= 8'd0;
    end else begin
      wr_pend_q <= wr_en;
      wr_stb_q  <= wr_pend_q;
      if (wr_en) begin
        wr_addr_q <= addr_q;
        wr_data_q <= rx_byte;
      end
    end
  end

  // Writable register file.
  // NOTE: this small array is reset entry by entry because every entry is
  // architecturally visible with a defined reset value; it is flops, not RAM.
  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < N_CTRL; i++) ctrl_q[i] <= CTRL_RST_VALS[i];
      int1_q <= INT_CFG_RST;
      int2_q <= INT_CFG_RST;
    end else if (wr_en) begin
      for (int i = 0; i < N_CTRL; i++) begin
        if (addr_q == ADDR_CTRL_REG1 + 6'(i)) ctrl_q[i] <= rx_byte;
      end
      if (addr_q == ADDR_INT1_CFG) int1_q <= rx_byte;
      if (addr_q == ADDR_INT2_CFG) int2_q <= rx_byte;
    end
  end

  // Sample capture: load directly when deselected, otherwise hold the latest
  // sample pending and apply it when the transaction ends.
  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      out_x_q    <= 16'd0;
      out_y_q    <= 16'd0;
      out_z_q    <= 16'd0;
      pend_x_q   <= 16'd0;
      pend_y_q   <= 16'd0;
      pend_z_q   <= 16'd0;
      pend_vld_q <= 1'b0;
    end else begin
      if (cs_rise) pend_vld_q <= 1'b0;
      if (SAMPLE_VLD) begin
        if (cs_s) begin
          out_x_q <= SAMPLE_X;
          out_y_q <= SAMPLE_Y;
          out_z_q <= SAMPLE_Z;
        end else begin
          pend_x_q   <= SAMPLE_X;
          pend_y_q   <= SAMPLE_Y;
          pend_z_q   <= SAMPLE_Z;
          pend_vld_q <= 1'b1;
        end
      end else if (cs_rise && pend_vld_q) begin
        out_x_q <= pend_x_q;
        out_y_q <= pend_y_q;
        out_z_q <= pend_z_q;
      end
    end
  end

  // Read map; unmapped addresses return zero.
  always_comb begin
    rd_data = 8'h00;
    case (rd_addr)
      ADDR_WHO_AM_I:  rd_data = WHO_AM_I_VAL;
      ADDR_CTRL_REG1: rd_data = ctrl_q[0];
      ADDR_CTRL_REG2: rd_data = ctrl_q[1];
      ADDR_CTRL_REG3: rd_data = ctrl_q[2];
      ADDR_CTRL_REG4: rd_data = ctrl_q[3];
      ADDR_CTRL_REG5: rd_data = ctrl_q[4];
      ADDR_CTRL_REG6: rd_data = ctrl_q[5];
      ADDR_OUT_X_L:   rd_data = out_x_q[7:0];
      ADDR_OUT_X_H:   rd_data = out_x_q[15:8];
      ADDR_OUT_Y_L:   rd_data = out_y_q[7:0];
      ADDR_OUT_Y_H:   rd_data = out_y_q[15:8];
      ADDR_OUT_Z_L:   rd_data = out_z_q[7:0];
      ADDR_OUT_Z_H:   rd_data = out_z_q[15:8];
      ADDR_INT1_CFG:  rd_data = int1_q;
      ADDR_INT2_CFG:  rd_data = int2_q;
      default:        rd_data = 8'h00;
    endcase
  end

  assign DO        = do_q;
  assign DO_OE     = do_oe_q;
  assign WR_STB    = wr_stb_q;
  assign WR_ADDR   = wr_addr_q;
  assign WR_DATA   = wr_data_q;
  assign CTRL_REG1 = ctrl_q[0];
  assign CTRL_REG2 = ctrl_q[1];
  assign CTRL_REG3 = ctrl_q[2];
  assign CTRL_REG4 = ctrl_q[3];
  assign CTRL_REG5 = ctrl_q[4];
  assign CTRL_REG6 = ctrl_q[5];

endmodule

// File: tb/tb_spi_accel_target.sv
// Directed bench for spi_accel_target: a table of single 16-bit frames plus
// hand-written sequences for auto-increment, aborts, pending samples and reset.
module tb_spi_accel_target;

  localparam int HALF = 8;   // SCLK half period in CLK_50 cycles
  localparam int NV   = 16;

  logic        CLK_50 = 1'b0;
  logic        RESET_N = 1'b0;
  logic        CS = 1'b1;
  logic        SCLK = 1'b1;
  logic        DIN = 1'b0;
  logic [15:0] SAMPLE_X = 16'h0;
  logic [15:0] SAMPLE_Y = 16'h0;
  logic [15:0] SAMPLE_Z = 16'h0;
  logic        SAMPLE_VLD = 1'b0;
  logic        DO, DO_OE, WR_STB;
  logic [5:0]  WR_ADDR;
  logic [7:0]  WR_DATA;
  logic [7:0]  CTRL_REG1, CTRL_REG2, CTRL_REG3, CTRL_REG4, CTRL_REG5, CTRL_REG6;

  spi_accel_target dut (
    .CLK_50     (CLK_50),
    .RESET_N    (RESET_N),
    .CS         (CS),
    .SCLK       (SCLK),
    .DIN        (DIN),
    .DO         (DO),
    .DO_OE      (DO_OE),
    .SAMPLE_X   (SAMPLE_X),
    .SAMPLE_Y   (SAMPLE_Y),
    .SAMPLE_Z   (SAMPLE_Z),
    .SAMPLE_VLD (SAMPLE_VLD),
    .WR_STB     (WR_STB),
    .WR_ADDR    (WR_ADDR),
    .WR_DATA    (WR_DATA),
    .CTRL_REG1  (CTRL_REG1),
    .CTRL_REG2  (CTRL_REG2),
    .CTRL_REG3  (CTRL_REG3),
    .CTRL_REG4  (CTRL_REG4),
    .CTRL_REG5  (CTRL_REG5),
    .CTRL_REG6  (CTRL_REG6)
  );

  always #10 CLK_50 = ~CLK_50;

  int checks = 0;
  int failures = 0;
  int stb_cnt = 0;

  // Counts every cycle WR_STB is high, so a stretched strobe counts twice.
  always @(posedge CLK_50) if (WR_STB === 1'b1) stb_cnt++;

  typedef struct {
    string       name;
    logic [15:0] frame;
    bit          is_read;
    logic [7:0]  exp_rd;
    int          exp_stb;
    logic [5:0]  exp_wa;
    logic [7:0]  exp_wd;
  } vec_t;

  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLK_50);
  endtask

  task automatic cs_start();
    @(negedge CLK_50);
    CS = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_end();
    CS = 1'b1;
    wait_clk(12);
  endtask

  // Shifts nbits (right-aligned in data, MSB first); returns what DO showed
  // just before each rising edge and how many of those samples had DO_OE high.
  task automatic shift_bits(input logic [31:0] data, input int nbits,
                            output logic [31:0] miso, output int oe_hi);
    miso  = '0;
    oe_hi = 0;
    for (int i = 0; i < nbits; i++) begin
      SCLK = 1'b0;
      DIN  = data[nbits-1-i];
      wait_clk(HALF);
      miso = {miso[30:0], DO};
      if (DO_OE === 1'b1) oe_hi++;
      SCLK = 1'b1;
      wait_clk(HALF);
    end
  endtask

  task automatic frame(input logic [31:0] data, input int nbits,
                       output logic [31:0] miso, output int oe_hi);
    cs_start();
    shift_bits(data, nbits, miso, oe_hi);
    cs_end();
  endtask

  task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    SAMPLE_X   = x;
    SAMPLE_Y   = y;
    SAMPLE_Z   = z;
    SAMPLE_VLD = 1'b1;
    wait_clk(1);
    SAMPLE_VLD = 1'b0;
  endtask

  initial begin
    logic [31:0] miso;
    int          oe;
    int          stb0;

    vecs[0]  = '{"wr_ctrl1",      16'h2097, 1'b0, 8'h00, 1, 6'h20, 8'h97};
    vecs[1]  = '{"rd_who_am_i",   16'h8F00, 1'b1, 8'h33, 0, 6'h00, 8'h00};
    vecs[2]  = '{"rd_ctrl1",      16'hA000, 1'b1, 8'h97, 0, 6'h00, 8'h00};
    vecs[3]  = '{"wr_ctrl6",      16'h2542, 1'b0, 8'h00, 1, 6'h25, 8'h42};
    vecs[4]  = '{"rd_ctrl6",      16'hA500, 1'b1, 8'h42, 0, 6'h00, 8'h00};
    vecs[5]  = '{"wr_int1",       16'h3081, 1'b0, 8'h00, 1, 6'h30, 8'h81};
    vecs[6]  = '{"rd_int1",       16'hB000, 1'b1, 8'h81, 0, 6'h00, 8'h00};
    vecs[7]  = '{"wr_int2",       16'h3412, 1'b0, 8'h00, 1, 6'h34, 8'h12};
    vecs[8]  = '{"rd_int2",       16'hB400, 1'b1, 8'h12, 0, 6'h00, 8'h00};
    vecs[9]  = '{"wr_who_am_i",   16'h0F55, 1'b0, 8'h00, 0, 6'h00, 8'h00};
    vecs[10] = '{"rd_who_am_i_2", 16'h8F00, 1'b1, 8'h33, 0, 6'h00, 8'h00};
    vecs[11] = '{"wr_out_x_l",    16'h2877, 1'b0, 8'h00, 0, 6'h00, 8'h00};
    vecs[12] = '{"rd_out_x_l",    16'hA800, 1'b1, 8'h00, 0, 6'h00, 8'h00};
    vecs[13] = '{"wr_unmapped",   16'h26AB, 1'b0, 8'h00, 0, 6'h00, 8'h00};
    vecs[14] = '{"rd_unmapped",   16'hA600, 1'b1, 8'h00, 0, 6'h00, 8'h00};
    vecs[15] = '{"rd_ctrl2",      16'hA100, 1'b1, 8'h00, 0, 6'h00, 8'h00};

    // Reset values while RESET_N is held low.
    wait_clk(3);
    check("rst_do",      DO,        1'b0);
    check("rst_do_oe",   DO_OE,     1'b0);
    check("rst_wr_stb",  WR_STB,    1'b0);
    check("rst_wr_addr", WR_ADDR,   6'h00);
    check("rst_wr_data", WR_DATA,   8'h00);
    check("rst_ctrl1",   CTRL_REG1, 8'h07);
    check("rst_ctrl2",   CTRL_REG2, 8'h00);
    check("rst_ctrl6",   CTRL_REG6, 8'h00);
    RESET_N = 1'b1;
    wait_clk(6);

    // SCLK toggling while deselected must not start anything.
    DIN = 1'b1;
    for (int i = 0; i < 8; i++) begin
      SCLK = 1'b0; wait_clk(HALF);
      SCLK = 1'b1; wait_clk(HALF);
    end
    DIN = 1'b0;
    check("idle_sclk_stb",   stb_cnt, 0);
    check("idle_sclk_do_oe", DO_OE,   1'b0);

    // Table of single frames.
    for (int i = 0; i < NV; i++) begin
      stb0 = stb_cnt;
      frame({16'h0, vecs[i].frame}, 16, miso, oe);
      check({vecs[i].name, "_oe"}, oe, vecs[i].is_read ? 8 : 0);
      if (vecs[i].is_read) begin
        check(vecs[i].name, miso[7:0], vecs[i].exp_rd);
      end else begin
        check({vecs[i].name, "_stb"}, stb_cnt - stb0, vecs[i].exp_stb);
        if (vecs[i].exp_stb > 0) begin
          check({vecs[i].name, "_wa"}, WR_ADDR, vecs[i].exp_wa);
          check({vecs[i].name, "_wd"}, WR_DATA, vecs[i].exp_wd);
        end
      end
    end
    check("ctrl1_after_table", CTRL_REG1, 8'h97);
    check("ctrl6_after_table", CTRL_REG6, 8'h42);

    // Sample load while deselected, then auto-increment reads of X and Z.
    pulse_sample(16'h1234, 16'hABCD, 16'h5678);
    wait_clk(3);
    frame(32'h00E80000, 24, miso, oe);
    check("ms_rd_x_l",  miso[15:8], 8'h34);
    check("ms_rd_x_h",  miso[7:0],  8'h12);
    check("ms_rd_x_oe", oe, 16);
    frame(32'h00EC0000, 24, miso, oe);
    check("ms_rd_z_l", miso[15:8], 8'h78);
    check("ms_rd_z_h", miso[7:0],  8'h56);

    // Auto-increment read stepping from an unmapped address into INT1_CFG.
    frame(32'h00EF0000, 24, miso, oe);
    check("ms_rd_2f", miso[15:8], 8'h00);
    check("ms_rd_30", miso[7:0],  8'h81);

    // Auto-increment write across CTRL_REG5 and CTRL_REG6.
    stb0 = stb_cnt;
    frame(32'h00641122, 24, miso, oe);
    check("ms_wr_stb",   stb_cnt - stb0, 2);
    check("ms_wr_ctrl5", CTRL_REG5, 8'h11);
    check("ms_wr_ctrl6", CTRL_REG6, 8'h22);
    check("ms_wr_wa",    WR_ADDR,   6'h25);
    check("ms_wr_wd",    WR_DATA,   8'h22);

    // Without auto-increment, extra bits after the data byte are ignored.
    stb0 = stb_cnt;
    frame(32'h00223344, 24, miso, oe);
    check("hold_wr_stb",   stb_cnt - stb0, 1);
    check("hold_wr_ctrl3", CTRL_REG3, 8'h33);
    check("hold_wr_ctrl4", CTRL_REG4, 8'h00);

    // Write aborted after 10 bits.
    stb0 = stb_cnt;
    frame(32'h2155 >> 6, 10, miso, oe);
    check("abort_wr_stb",   stb_cnt - stb0, 0);
    check("abort_wr_ctrl2", CTRL_REG2, 8'h00);
    check("abort_wr_do_oe", DO_OE, 1'b0);

    // Read aborted after 12 bits: DO_OE drops shortly after CS rises.
    cs_start();
    shift_bits(32'h8F00 >> 4, 12, miso, oe);
    check("abort_rd_oe_during", oe, 4);
    CS = 1'b1;
    wait_clk(4);
    check("abort_rd_do_oe", DO_OE, 1'b0);
    wait_clk(8);

    // Samples arriving mid-read are held; the last one wins after CS rises.
    cs_start();
    shift_bits(32'hAD, 8, miso, oe);
    pulse_sample(16'h9999, 16'h0000, 16'h7000);
    wait_clk(2);
    pulse_sample(16'h1234, 16'h0000, 16'h8000);
    shift_bits(32'h00, 8, miso, oe);
    check("pend_rd_old_z_h", miso[7:0], 8'h56);
    check("pend_rd_oe", oe, 8);
    cs_end();
    frame(32'hAD00, 16, miso, oe);
    check("pend_new_z_h", miso[7:0], 8'h80);
    frame(32'hA900, 16, miso, oe);
    check("pend_new_x_h", miso[7:0], 8'h12);

    // Reset in the middle of a write frame discards it.
    stb0 = stb_cnt;
    cs_start();
    shift_bits(32'h20FF >> 5, 11, miso, oe);
    RESET_N = 1'b0;
    wait_clk(2);
    check("midrst_do_oe", DO_OE, 1'b0);
    RESET_N = 1'b1;
    wait_clk(2);
    shift_bits(32'h1F, 5, miso, oe);
    cs_end();
    check("midrst_stb",   stb_cnt - stb0, 0);
    check("midrst_ctrl1", CTRL_REG1, 8'h07);
    check("midrst_ctrl5", CTRL_REG5, 8'h00);
    frame(32'hA000, 16, miso, oe);
    check("midrst_rd_ctrl1", miso[7:0], 8'h07);
    frame(32'hAD00, 16, miso, oe);
    check("midrst_rd_z_h", miso[7:0], 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
